mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single backing-memory port between the I-side requester (instruction cache refill behind the fetch stage) and the D-side requester (data cache / MEM stage).
- Fixed priority with D-side preferred, plus an anti-starvation counter for the I-side.
- One outstanding transaction at a time; every requester- and memory-facing output is registered.

Parameters:
- ADDR_W, 64, address width on all ports
- LINE_W, 64, data width of read and write payloads
- STARVE_MAX, 4, consecutive contended D-side wins before the I-side is forced to win
- TIMEOUT, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- IC_REQ  in  1  I-side read request (level)
- IC_ADDR  in  ADDR_W  I-side address
- IC_GNT  out  1  one-cycle pulse: I-side request accepted
- IC_RVALID  out  1  one-cycle pulse: I-side response valid
- IC_RDATA  out  LINE_W  I-side read data
- IC_ERR  out  1  I-side error flag, qualified by IC_RVALID
- DC_REQ  in  1  D-side request (level)
- DC_WE  in  1  D-side write enable (1 = write)
- DC_ADDR  in  ADDR_W  D-side address
- DC_WDATA  in  LINE_W  D-side write data
- DC_GNT  out  1  one-cycle pulse: D-side request accepted
- DC_RVALID  out  1  one-cycle pulse: D-side response (read data or write ack)
- DC_RDATA  out  LINE_W  D-side read data
- DC_ERR  out  1  D-side error flag, qualified by DC_RVALID
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  LINE_W  memory write data
- MEM_READY  in  1  memory accepts the request while MEM_REQ is high
- MEM_RVALID  in  1  memory response / write ack
- MEM_RDATA  in  LINE_W  memory read data

Behaviour:
- Clock, reset and interface: one clock, CLK; RESET is asynchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0; all outputs 0, all data and address outputs 0.
- Reset during any state drops the transaction. No RVALID is produced for it.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Sample IC_REQ/DC_REQ at the clock edge.
  - Winner: DC if only DC requests; IC if only IC requests.
  - If both request: DC wins unless starve_cnt==STARVE_MAX, in which case IC wins.
  - On a win: latch owner, address, WE and WDATA; go to ISSUE.
  - In the following cycle, the winner's GNT=1 for exactly one cycle, and MEM_REQ=1 with the latched ADDR/WE/WDATA.
  - IC_WE is implicitly 0 for I-side requests.
- starve_cnt:
  - Increments when DC wins while IC_REQ=1.
  - Clears when IC wins.
  - Saturates at STARVE_MAX.
- ISSUE:
  - Hold MEM_REQ and its fields stable until MEM_READY is sampled 1.
  - Next cycle: MEM_REQ=0, go to WAIT.
- WAIT:
  - On MEM_RVALID=1, register MEM_RDATA to the owner's RDATA and pulse the owner's RVALID (ERR=0) in the next cycle; go to IDLE.
  - A write response uses RDATA=0.
- Latency: request sampled at edge N → GNT and MEM_REQ in cycle N+1. MEM_RVALID at edge M → RVALID in cycle M+1.
- New arbitration may occur in the same cycle RVALID is high, giving back-to-back transactions.
- Requester contract:
  - Hold REQ and its fields stable until GNT is seen.
  - Drop REQ in the cycle after GNT, or keep it high to issue a new request. Any REQ sampled in IDLE is a new request.
- Non-owner RDATA is unchanged; RVALID is never asserted to the non-owner.
- MEM_RVALID in IDLE or ISSUE is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entry to ISSUE and counts during ISSUE and WAIT.
  - When it reaches TIMEOUT without completion: MEM_REQ=0; the owner gets RVALID=1, ERR=1, RDATA=0 in the next cycle; go to IDLE.
  - A late MEM_RVALID is then ignored.
- Without the macro: the FSM waits indefinitely, and IC_ERR/DC_ERR are tied 0.

Test Plan:
- IC_REQ=1, IC_ADDR=0x1000, MEM_READY=1, MEM_RVALID 3 cycles later with RDATA=0xDEADBEEF → IC_GNT one pulse, MEM_ADDR=0x1000, IC_RVALID one pulse with IC_RDATA=0xDEADBEEF, DC outputs idle.
- IC_REQ and DC_REQ raised together, DC write ADDR=0x2000 WDATA=0x55 → DC_GNT first, MEM_WE=1, MEM_WDATA=0x55, DC_RVALID ack; then IC granted with no idle cycle between the RVALID and the GNT.
- Both requesters held continuously, STARVE_MAX=4 → grant order DC,DC,DC,DC,IC,DC...
- MEM_READY held 0 for 5 cycles → MEM_REQ and MEM_ADDR stable for all 5 cycles, exactly one GNT pulse.
- RESET asserted asynchronously in WAIT → all outputs 0 immediately; MEM_RVALID after release produces no RVALID.
- ARB_TIMEOUT_EN, TIMEOUT=8, MEM_RVALID never returned → owner RVALID=1, ERR=1 after 8 cycles; FSM in IDLE and accepting new requests.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between the I-side
// (icache refill) and D-side (dcache) requesters. D-side has fixed
// priority; a starvation counter forces an I-side win after STARVE_MAX
// consecutive contended D-side wins. One transaction in flight at a time,
// and every requester/memory-facing output comes straight from a flop.
// Optional build macro: ARB_TIMEOUT_EN (watchdog that ends a stuck
// transaction with an error response after TIMEOUT cycles).
//
// Handshake semantics: IC_REQ/DC_REQ are levels held with their fields
// until the matching GNT pulse; GNT pulses for exactly one cycle when the
// request is taken. MEM_REQ and its fields stay stable until MEM_READY is
// sampled high. MEM_RVALID is honoured only while waiting for a response,
// and produces one RVALID pulse to the owner only.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int LINE_W     = 64,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IC_REQ,
    input  logic [ADDR_W-1:0] IC_ADDR,
    output logic              IC_GNT,
    output logic              IC_RVALID,
    output logic [LINE_W-1:0] IC_RDATA,
    output logic              IC_ERR,
    input  logic              DC_REQ,
    input  logic              DC_WE,
    input  logic [ADDR_W-1:0] DC_ADDR,
    input  logic [LINE_W-1:0] DC_WDATA,
    output logic              DC_GNT,
    output logic              DC_RVALID,
    output logic [LINE_W-1:0] DC_RDATA,
    output logic              DC_ERR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [LINE_W-1:0] MEM_WDATA,
    input  logic              MEM_READY,
    input  logic              MEM_RVALID,
    input  logic [LINE_W-1:0] MEM_RDATA,
    output logic [1:0]        o_dbg_state
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_owner_dc;
    logic              r_ic_gnt;
    logic              r_dc_gnt;
    logic              r_ic_rvalid;
    logic              r_dc_rvalid;
    logic [LINE_W-1:0] r_ic_rdata;
    logic [LINE_W-1:0] r_dc_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
    logic              w_win_ic;
    logic              w_win_dc;
    logic              w_accept;
    logic              w_resp;
    logic              w_tmo;

    assign w_accept = (r_state == S_ISSUE) && MEM_READY;
    assign w_resp   = (r_state == S_WAIT) && MEM_RVALID;

`ifdef ARB_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT + 1);
    logic [TC_W-1:0] r_tmo_cnt;
    logic            r_ic_err;
    logic            r_dc_err;

    // Watchdog: cleared on each grant, counts every cycle spent in ISSUE/WAIT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tmo_cnt <= '0;
        end else if (w_win_ic || w_win_dc) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // A real response in the same cycle wins over the watchdog.
    assign w_tmo = (r_state != S_IDLE) && (r_tmo_cnt == TC_W'(TIMEOUT - 1)) && !w_resp;

    // Error flags accompany the timeout RVALID pulse only.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ic_err <= 1'b0;
            r_dc_err <= 1'b0;
        end else begin
            r_ic_err <= w_tmo && !r_owner_dc;
            r_dc_err <= w_tmo && r_owner_dc;
        end
    end

    assign IC_ERR = r_ic_err;
    assign DC_ERR = r_dc_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_tmo  = 1'b0;
    assign IC_ERR = 1'b0;
    assign DC_ERR = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration and next-state decode.
    always_comb begin
        w_win_ic     = 1'b0;
        w_win_dc     = 1'b0;
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (DC_REQ && IC_REQ) begin
                    if (r_starve_cnt == SC_W'(STARVE_MAX)) begin
                        w_win_ic = 1'b1;
                    end else begin
                        w_win_dc = 1'b1;
                    end
                end else if (DC_REQ) begin
                    w_win_dc = 1'b1;
                end else if (IC_REQ) begin
                    w_win_ic = 1'b1;
                end
                if (DC_REQ || IC_REQ) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_tmo) begin
                    w_next_state = S_IDLE;
                end else if (w_accept) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_resp || w_tmo) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Starvation counter: counts contended D-side wins, saturating.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_starve_cnt <= '0;
        end else if (w_win_ic) begin
            r_starve_cnt <= '0;
        end else if (w_win_dc && IC_REQ && (r_starve_cnt != SC_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Registered grant, memory request and response datapath.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_owner_dc  <= 1'b0;
            r_ic_gnt    <= 1'b0;
            r_dc_gnt    <= 1'b0;
            r_ic_rvalid <= 1'b0;
            r_dc_rvalid <= 1'b0;
            r_ic_rdata  <= '0;
            r_dc_rdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_ic_gnt    <= w_win_ic;
            r_dc_gnt    <= w_win_dc;
            r_ic_rvalid <= 1'b0;
            r_dc_rvalid <= 1'b0;
            if (w_win_ic || w_win_dc) begin
                r_owner_dc  <= w_win_dc;
                r_mem_req   <= 1'b1;
                r_mem_addr  <= w_win_dc ? DC_ADDR : IC_ADDR;
                r_mem_we    <= w_win_dc && DC_WE;
                r_mem_wdata <= w_win_dc ? DC_WDATA : '0;
            end else if ((r_state == S_ISSUE) && (w_accept || w_tmo)) begin
                r_mem_req <= 1'b0;
            end
            if (w_resp || w_tmo) begin
                if (r_owner_dc) begin
                    r_dc_rvalid <= 1'b1;
                    r_dc_rdata  <= (w_tmo || r_mem_we) ? '0 : MEM_RDATA;
                end else begin
                    r_ic_rvalid <= 1'b1;
                    r_ic_rdata  <= w_tmo ? '0 : MEM_RDATA;
                end
            end
        end
    end

    assign IC_GNT      = r_ic_gnt;
    assign DC_GNT      = r_dc_gnt;
    assign IC_RVALID   = r_ic_rvalid;
    assign DC_RVALID   = r_dc_rvalid;
    assign IC_RDATA    = r_ic_rdata;
    assign DC_RDATA    = r_dc_rdata;
    assign MEM_REQ     = r_mem_req;
    assign MEM_WE      = r_mem_we;
    assign MEM_ADDR    = r_mem_addr;
    assign MEM_WDATA   = r_mem_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a
// transaction-level reference model, a per-cycle compare process, and a
// response-data scoreboard fed with hand-computed values.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IC_REQ = 1'b0;
    logic [63:0] IC_ADDR = '0;
    logic        DC_REQ = 1'b0;
    logic        DC_WE = 1'b0;
    logic [63:0] DC_ADDR = '0;
    logic [63:0] DC_WDATA = '0;
    logic        MEM_READY = 1'b0;
    logic        MEM_RVALID = 1'b0;
    logic [63:0] MEM_RDATA = '0;
    logic        IC_GNT, IC_RVALID, IC_ERR, DC_GNT, DC_RVALID, DC_ERR;
    logic        MEM_REQ, MEM_WE;
    logic [63:0] IC_RDATA, DC_RDATA, MEM_ADDR, MEM_WDATA;
    logic [1:0]  dbg_state;

    initial forever #5 CLK = ~CLK;

    mem_port_arbiter #(
        .ADDR_W(64), .LINE_W(64), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .IC_REQ(IC_REQ), .IC_ADDR(IC_ADDR), .IC_GNT(IC_GNT), .IC_RVALID(IC_RVALID),
        .IC_RDATA(IC_RDATA), .IC_ERR(IC_ERR),
        .DC_REQ(DC_REQ), .DC_WE(DC_WE), .DC_ADDR(DC_ADDR), .DC_WDATA(DC_WDATA),
        .DC_GNT(DC_GNT), .DC_RVALID(DC_RVALID), .DC_RDATA(DC_RDATA), .DC_ERR(DC_ERR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_READY(MEM_READY), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
        .o_dbg_state(dbg_state)
    );

    // ---------------- checking infrastructure ----------------
    int total = 0;
    int bad = 0;
    int ic_gnt_n = 0;
    int dc_gnt_n = 0;
    bit gnt_log[$];
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One transaction at a time: free -> granted (memory not yet taken)
    // -> accepted (awaiting response) -> free. m_age counts cycles since
    // grant, the grant cycle being cycle 1.
    bit          m_busy = 1'b0;
    bit          m_accepted = 1'b0;
    bit          m_owner_dc = 1'b0;
    int          m_starve = 0;
    int          m_age = 0;
    logic        e_ic_gnt = 1'b0, e_dc_gnt = 1'b0, e_ic_rvalid = 1'b0, e_dc_rvalid = 1'b0;
    logic        e_ic_err = 1'b0, e_dc_err = 1'b0, e_mem_req = 1'b0, e_mem_we = 1'b0;
    logic [63:0] e_ic_rdata = '0, e_dc_rdata = '0, e_mem_addr = '0, e_mem_wdata = '0;
    wire         m_ic_wins = IC_REQ && (!DC_REQ || (m_starve == STARVE_MAX));

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_busy <= 1'b0; m_accepted <= 1'b0; m_owner_dc <= 1'b0; m_starve <= 0; m_age <= 0;
            e_ic_gnt <= 1'b0; e_dc_gnt <= 1'b0; e_ic_rvalid <= 1'b0; e_dc_rvalid <= 1'b0;
            e_ic_err <= 1'b0; e_dc_err <= 1'b0; e_mem_req <= 1'b0; e_mem_we <= 1'b0;
            e_ic_rdata <= '0; e_dc_rdata <= '0; e_mem_addr <= '0; e_mem_wdata <= '0;
        end else begin
            e_ic_gnt <= 1'b0; e_dc_gnt <= 1'b0; e_ic_rvalid <= 1'b0; e_dc_rvalid <= 1'b0;
            e_ic_err <= 1'b0; e_dc_err <= 1'b0;
            if (!m_busy) begin
                if (IC_REQ || DC_REQ) begin
                    m_busy      <= 1'b1;
                    m_accepted  <= 1'b0;
                    m_age       <= 1;
                    m_owner_dc  <= !m_ic_wins;
                    e_mem_req   <= 1'b1;
                    e_mem_addr  <= m_ic_wins ? IC_ADDR : DC_ADDR;
                    e_mem_we    <= !m_ic_wins && DC_WE;
                    e_mem_wdata <= m_ic_wins ? 64'd0 : DC_WDATA;
                    e_ic_gnt    <= m_ic_wins;
                    e_dc_gnt    <= !m_ic_wins;
                    if (m_ic_wins) m_starve <= 0;
                    else if (IC_REQ && m_starve < STARVE_MAX) m_starve <= m_starve + 1;
                end
            end else if (TMO_ON && (m_age == TIMEOUT) && !(m_accepted && MEM_RVALID)) begin
                m_busy    <= 1'b0;
                e_mem_req <= 1'b0;
                if (m_owner_dc) begin
                    e_dc_rvalid <= 1'b1; e_dc_err <= 1'b1; e_dc_rdata <= '0;
                end else begin
                    e_ic_rvalid <= 1'b1; e_ic_err <= 1'b1; e_ic_rdata <= '0;
                end
            end else if (m_accepted && MEM_RVALID) begin
                m_busy <= 1'b0;
                if (m_owner_dc) begin
                    e_dc_rvalid <= 1'b1; e_dc_rdata <= e_mem_we ? 64'd0 : MEM_RDATA;
                end else begin
                    e_ic_rvalid <= 1'b1; e_ic_rdata <= MEM_RDATA;
                end
            end else begin
                m_age <= m_age + 1;
                if (!m_accepted && MEM_READY) begin
                    m_accepted <= 1'b1;
                    e_mem_req  <= 1'b0;
                end
            end
        end
    end

    // ---------------- compare process (every falling edge) ----------------
    initial forever begin
        @(negedge CLK);
        chk("ic_gnt", IC_GNT, e_ic_gnt);
        chk("dc_gnt", DC_GNT, e_dc_gnt);
        chk("ic_rvalid", IC_RVALID, e_ic_rvalid);
        chk("dc_rvalid", DC_RVALID, e_dc_rvalid);
        chk("ic_err", IC_ERR, e_ic_err);
        chk("dc_err", DC_ERR, e_dc_err);
        chk("ic_rdata", IC_RDATA, e_ic_rdata);
        chk("dc_rdata", DC_RDATA, e_dc_rdata);
        chk("mem_req", MEM_REQ, e_mem_req);
        chk("mem_we", MEM_WE, e_mem_we);
        chk("mem_addr", MEM_ADDR, e_mem_addr);
        chk("mem_wdata", MEM_WDATA, e_mem_wdata);
        if (IC_GNT) begin ic_gnt_n++; gnt_log.push_back(1'b0); end
        if (DC_GNT) begin dc_gnt_n++; gnt_log.push_back(1'b1); end
        if (IC_RVALID || DC_RVALID) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected: got RVALID ic=%0d dc=%0d, required none", IC_RVALID, DC_RVALID);
            end else begin
                chk("rsp_data", IC_RVALID ? IC_RDATA : DC_RDATA, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_gnt(output bit got_dc);
        got_dc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (IC_GNT || DC_GNT) begin
                got_dc = DC_GNT;
                return;
            end
        end
        total++; bad++;
        $display("FAIL gnt_wait: got no grant in 20 cycles, required one");
    endtask

    // Called in the grant cycle (or a later ISSUE cycle once MEM_READY is
    // high); returns in the RVALID cycle.
    task automatic finish_resp(input logic [63:0] data);
        step();
        MEM_RVALID = 1'b1; MEM_RDATA = data;
        step();
        MEM_RVALID = 1'b0; MEM_RDATA = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, required to finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bit d;
        int n;
        int n0;
        bit exp_order [6];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        step(); step();
        chk("rst_mem_req", MEM_REQ, 0);
        chk("rst_mem_addr", MEM_ADDR, 0);
        RESET = 1'b0;
        step();

        // T1: single I-side read
        IC_REQ = 1'b1; IC_ADDR = 64'h1000; MEM_READY = 1'b1;
        exp_q.push_back(64'hDEADBEEF);
        wait_gnt(d);
        chk("t1_owner_dc", d, 0);
        chk("t1_mem_addr", MEM_ADDR, 64'h1000);
        chk("t1_mem_req", MEM_REQ, 1);
        IC_REQ = 1'b0;
        step(); step(); step();
        MEM_RVALID = 1'b1; MEM_RDATA = 64'hDEADBEEF;
        step();
        MEM_RVALID = 1'b0; MEM_RDATA = '0;
        chk("t1_ic_rvalid", IC_RVALID, 1);
        chk("t1_ic_rdata", IC_RDATA, 64'hDEADBEEF);
        chk("t1_dc_rvalid", DC_RVALID, 0);
        chk("t1_ic_gnt_count", ic_gnt_n, 1);
        step();

        // T2: simultaneous requests, D-side write first, then I-side back-to-back
        IC_REQ = 1'b1; IC_ADDR = 64'h3000;
        DC_REQ = 1'b1; DC_WE = 1'b1; DC_ADDR = 64'h2000; DC_WDATA = 64'h55;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'hCAFE);
        wait_gnt(d);
        chk("t2_owner_dc", d, 1);
        chk("t2_mem_we", MEM_WE, 1);
        chk("t2_mem_wdata", MEM_WDATA, 64'h55);
        chk("t2_mem_addr", MEM_ADDR, 64'h2000);
        DC_REQ = 1'b0; DC_WE = 1'b0;
        finish_resp(64'h1234);
        chk("t2_dc_rvalid", DC_RVALID, 1);
        chk("t2_dc_rdata_wr", DC_RDATA, 0);
        step();
        chk("t2_ic_gnt_b2b", IC_GNT, 1);
        chk("t2_ic_addr", MEM_ADDR, 64'h3000);
        IC_REQ = 1'b0;
        finish_resp(64'hCAFE);
        chk("t2_ic_rdata", IC_RDATA, 64'hCAFE);
        step();

        // T3: both held continuously, starvation order
        gnt_log.delete();
        IC_REQ = 1'b1; IC_ADDR = 64'h7000;
        DC_REQ = 1'b1; DC_ADDR = 64'h8000; DC_WE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(64'h100 + 64'(i));
            wait_gnt(d);
            finish_resp(64'h100 + 64'(i));
        end
        IC_REQ = 1'b0; DC_REQ = 1'b0;
        chk("t3_gnt_count", gnt_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < gnt_log.size()) chk($sformatf("t3_order%0d", i), gnt_log[i], exp_order[i]);
        end
        step();

        // T4: MEM_READY low stall, request held stable
        MEM_READY = 1'b0;
        DC_REQ = 1'b1; DC_ADDR = 64'h4000;
        exp_q.push_back(64'h44);
        n0 = dc_gnt_n;
        wait_gnt(d);
        DC_REQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            chk("t4_mem_req", MEM_REQ, 1);
            chk("t4_mem_addr", MEM_ADDR, 64'h4000);
        end
        chk("t4_one_gnt", dc_gnt_n - n0, 1);
        MEM_READY = 1'b1;
        finish_resp(64'h44);
        chk("t4_dc_rdata", DC_RDATA, 64'h44);
        step();

        // T5: asynchronous reset while waiting for the response
        DC_REQ = 1'b1; DC_ADDR = 64'h5000;
        wait_gnt(d);
        DC_REQ = 1'b0;
        step();
        #2;
        RESET = 1'b1;
        #1;
        chk("t5_mem_addr", MEM_ADDR, 0);
        chk("t5_mem_req", MEM_REQ, 0);
        chk("t5_dc_rdata", DC_RDATA, 0);
        chk("t5_dc_gnt", DC_GNT, 0);
        step(); step();
        RESET = 1'b0;
        step();
        MEM_RVALID = 1'b1; MEM_RDATA = 64'h99;
        step();
        MEM_RVALID = 1'b0; MEM_RDATA = '0;
        step();
        chk("t5_no_rvalid", DC_RVALID, 0);
        step();

`ifdef ARB_TIMEOUT_EN
        // T6: memory never responds, watchdog completes with error
        IC_REQ = 1'b1; IC_ADDR = 64'h6000; MEM_READY = 1'b1;
        exp_q.push_back(64'h0);
        wait_gnt(d);
        IC_REQ = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (IC_RVALID) break;
        end
        chk("t6_latency", n, TIMEOUT);
        chk("t6_ic_err", IC_ERR, 1);
        chk("t6_ic_rdata", IC_RDATA, 0);
        MEM_RVALID = 1'b1; MEM_RDATA = 64'h77;
        step();
        MEM_RVALID = 1'b0; MEM_RDATA = '0;
        DC_REQ = 1'b1; DC_ADDR = 64'h9000;
        exp_q.push_back(64'h9);
        wait_gnt(d);
        chk("t6_new_owner_dc", d, 1);
        DC_REQ = 1'b0;
        finish_resp(64'h9);
        chk("t6_dc_err", DC_ERR, 0);
        step();
`else
        n = 0;
`endif

        step(); step();
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
